async_operand_issue: RTL



---
 rtl/async_operand_issue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/async_operand_issue.sv
// async_operand_issue: clocked host to dual-rail operand issue stage with a four-phase RZ handshake.
// Optional ASYNC_ISSUE_ACK_SYNC_EN: 2-flop ack synchronizers instead of a single sampling flop.

package pa_AsyncCordic;
  parameter int RW = 15;
  parameter int EW = 7;

  typedef struct packed {
    logic data_1;
    logic data_0;
  } dual_rail_t;

  typedef struct packed {
    dual_rail_t [RW:0] radicand;
    dual_rail_t [EW:0] exp;
  } operand_t;
endpackage

// state  | meaning
// IDLE   | spacer on outputs, ready for a host operand once acks are low
// DATA   | codeword driven, waiting for both acks high
// SPACER | spacer driven, waiting for both acks low
module async_operand_issue #(
  parameter int RW      = pa_AsyncCordic::RW,
  parameter int EW      = pa_AsyncCordic::EW,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       in_valid,
  input  logic [RW:0]                in_radicand,
  input  logic [EW:0]                in_exp,
  output logic                       in_ready,
  output pa_AsyncCordic::operand_t   data_x,
  output pa_AsyncCordic::dual_rail_t ctrl,
  input  logic                       x_ack,
  input  logic                       ctrl_ack,
  output logic                       busy,
  output logic                       err_timeout
);

`ifdef ASYNC_ISSUE_ACK_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ERR = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    SPACER = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] x_sync_q, c_sync_q, fill_q;
  logic                   ack_hi, ack_lo;
  logic                   accept, leave_data;
  logic [CW-1:0]          phase_cnt_q;

  function automatic pa_AsyncCordic::operand_t encode(input logic [RW:0] r, input logic [EW:0] e);
    pa_AsyncCordic::operand_t o;
    o = '0;
    for (int i = 0; i <= RW; i++) begin
      o.radicand[i].data_1 = r[i];
      o.radicand[i].data_0 = ~r[i];
    end
    for (int i = 0; i <= EW; i++) begin
      o.exp[i].data_1 = e[i];
      o.exp[i].data_0 = ~e[i];
    end
    return o;
  endfunction

  // fill_q marks when the sampled acks reflect post-reset input, so in_ready cannot rise on reset values
  always_ff @(posedge clk) begin
    if (!arstn) begin
      x_sync_q <= '0;
      c_sync_q <= '0;
      fill_q   <= '0;
    end else begin
      x_sync_q[0] <= x_ack;
      c_sync_q[0] <= ctrl_ack;
      fill_q[0]   <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        x_sync_q[i] <= x_sync_q[i-1];
        c_sync_q[i] <= c_sync_q[i-1];
        fill_q[i]   <= fill_q[i-1];
      end
    end
  end

  assign ack_hi = x_sync_q[SYNC_STAGES-1] && c_sync_q[SYNC_STAGES-1];
  assign ack_lo = !x_sync_q[SYNC_STAGES-1] && !c_sync_q[SYNC_STAGES-1] && fill_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!arstn) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    leave_data = 1'b0;
    in_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ack_lo;
        if (in_valid && ack_lo) begin
          accept  = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (ack_hi) begin
          leave_data = 1'b1;
          state_d    = SPACER;
        end
      end
      SPACER: begin
        if (ack_lo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Whole word switches in one edge: codeword on accept, all-zero spacer on leaving DATA
  always_ff @(posedge clk) begin
    if (!arstn) begin
      data_x <= '0;
      ctrl   <= '0;
      busy   <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (accept) begin
        data_x      <= encode(in_radicand, in_exp);
        ctrl.data_1 <= in_exp[0];
        ctrl.data_0 <= ~in_exp[0];
      end else if (leave_data) begin
        data_x <= '0;
        ctrl   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      phase_cnt_q <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        phase_cnt_q <= '0;
      end else if (state_q != IDLE && phase_cnt_q != CNT_MAX) begin
        phase_cnt_q <= phase_cnt_q + 1'b1;
      end
      if (TIMEOUT != 0 && state_q != IDLE && phase_cnt_q == CNT_ERR) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule
